// File: rtl/canvas_pkg.sv
// Shared types and sizes for the 32x32 pen canvas.
// The optional erase-write feature is enabled by defining CANVAS_ERASE_EN.
package canvas_pkg;

  localparam int IMG_W    = 32;
  localparam int IMG_H    = 32;
  localparam int IMG_BITS = IMG_W * IMG_H;
  localparam int CNT_W    = 11;
  localparam int ROW_W    = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  // Row-major bit index: y*32 + x.
  function automatic logic [9:0] pix_index(input logic [4:0] x, input logic [4:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/row_popcount.sv
// Combinational population count of one 32-pixel canvas row.
module row_popcount (
  input  logic [31:0] row_bits,
  output logic [5:0]  row_count
);

  always_comb begin
    row_count = '0;
    for (int i = 0; i < 32; i++) begin
      row_count = row_count + {5'd0, row_bits[i]};
    end
  end

endmodule

// File: rtl/canvas_writer.sv
// Live 32x32 canvas with pen writes, row-sweep clear, snapshot frame and set-pixel count.
// Define CANVAS_ERASE_EN to add the wr_erase port (erase writes clear pixels).
//
// Handshakes: a write transfers on a rising edge where wr_valid & wr_ready; wr_ready is
// combinational and never depends on wr_valid. frame_valid holds the snapshot until a cycle
// with frame_ack high releases it.
module canvas_writer
  import canvas_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [4:0]          wr_x,
  input  logic [4:0]          wr_y,
`ifdef CANVAS_ERASE_EN
  input  logic                wr_erase,
`endif
  input  logic                clr_req,
  output logic                busy,
  input  logic                snap_req,
  output logic                frame_valid,
  input  logic                frame_ack,
  output logic [IMG_BITS-1:0] live_image,
  output logic [IMG_BITS-1:0] frame_image,
  output logic [CNT_W-1:0]    pix_count,
  output state_e              dbg_state
);

  state_e              state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [IMG_BITS-1:0] live_q, live_d;
  logic [IMG_BITS-1:0] frame_q, frame_d;
  logic                fv_q, fv_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [9:0]          wr_idx;
  logic                do_erase;
  logic [IMG_W-1:0]    sweep_row;
  logic [5:0]          sweep_pop;

`ifdef CANVAS_ERASE_EN
  assign do_erase = wr_erase;
`else
  assign do_erase = 1'b0;
`endif

  assign wr_idx    = pix_index(wr_x, wr_y);
  assign sweep_row = live_q[{row_q, 5'd0} +: IMG_W];

  row_popcount u_row_popcount (
    .row_bits  (sweep_row),
    .row_count (sweep_pop)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    live_d  = live_q;
    frame_d = frame_q;
    fv_d    = fv_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        // A clear request pre-empts any write offered in the same cycle.
        if (clr_req) begin
          state_d = CLEAR;
          row_d   = '0;
        end else if (wr_valid) begin
          if (do_erase) begin
            if (live_q[wr_idx]) begin
              live_d[wr_idx] = 1'b0;
              cnt_d          = cnt_q - 11'd1;
            end
          end else if (!live_q[wr_idx]) begin
            live_d[wr_idx] = 1'b1;
            cnt_d          = cnt_q + 11'd1;
          end
        end
      end
      CLEAR: begin
        live_d[{row_q, 5'd0} +: IMG_W] = '0;
        cnt_d = cnt_q - {5'd0, sweep_pop};
        row_d = row_q + 5'd1;
        if (row_q == 5'd31) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Capture uses the pre-write bitmap; a held frame blocks new captures.
    if (fv_q) begin
      if (frame_ack) begin
        fv_d = 1'b0;
      end
    end else if (snap_req && (state_q == IDLE)) begin
      frame_d = live_q;
      fv_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      live_q  <= '0;
      frame_q <= '0;
      fv_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      live_q  <= live_d;
      frame_q <= frame_d;
      fv_q    <= fv_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wr_ready    = (state_q == IDLE) && !clr_req;
  assign busy        = (state_q == CLEAR);
  assign frame_valid = fv_q;
  assign live_image  = live_q;
  assign frame_image = frame_q;
  assign pix_count   = cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_canvas_writer.sv
// Bench for canvas_writer: directed scenarios plus random traffic against a bitmap model.
module tb_canvas_writer;
  import canvas_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                wr_valid;
  logic                wr_ready;
  logic [4:0]          wr_x;
  logic [4:0]          wr_y;
  logic                wr_erase;
  logic                clr_req;
  logic                busy;
  logic                snap_req;
  logic                frame_valid;
  logic                frame_ack;
  logic [IMG_BITS-1:0] live_image;
  logic [IMG_BITS-1:0] frame_image;
  logic [CNT_W-1:0]    pix_count;
  state_e              dbg_state;

  always #5 clk = ~clk;

  canvas_writer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
`ifdef CANVAS_ERASE_EN
    .wr_erase    (wr_erase),
`endif
    .clr_req     (clr_req),
    .busy        (busy),
    .snap_req    (snap_req),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack),
    .live_image  (live_image),
    .frame_image (frame_image),
    .pix_count   (pix_count),
    .dbg_state   (dbg_state)
  );

  typedef struct packed {
    logic [1023:0] live;
    logic [1023:0] frame;
    logic          fv;
    logic          busy;
    logic [10:0]   cnt;
    logic          ready;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // Reference model: plain bit array, clear progress as a row number.
  logic [1023:0] m_img;
  logic [1023:0] m_frame;
  bit            m_fv;
  bit            m_clearing;
  int            m_row;

  task automatic model_step(input bit rstn, input bit clr, input bit wv, input int x, input int y,
                            input bit er, input bit snap, input bit ack);
    logic [1023:0] img_before;
    bit            idle_before;
    bit            fv_before;
    if (!rstn) begin
      m_img = '0; m_frame = '0; m_fv = 0; m_clearing = 0; m_row = 0;
      return;
    end
    img_before  = m_img;
    idle_before = !m_clearing;
    fv_before   = m_fv;
    if (m_clearing) begin
      for (int i = 0; i < 32; i++) m_img[m_row*32 + i] = 1'b0;
      m_row++;
      if (m_row == 32) m_clearing = 0;
    end else if (clr) begin
      m_clearing = 1;
      m_row      = 0;
    end else if (wv) begin
`ifdef CANVAS_ERASE_EN
      m_img[y*32 + x] = er ? 1'b0 : 1'b1;
`else
      m_img[y*32 + x] = 1'b1;
`endif
    end
    if (fv_before) begin
      if (ack) m_fv = 0;
    end else if (snap && idle_before) begin
      m_frame = img_before;
      m_fv    = 1;
    end
  endtask

  task automatic cycle(input bit rstn, input bit clr, input bit wv, input int x, input int y,
                       input bit er, input bit snap, input bit ack);
    exp_t e;
    @(negedge clk);
    rst_n    = rstn;
    clr_req  = clr;
    wr_valid = wv;
    wr_x     = 5'(x);
    wr_y     = 5'(y);
    wr_erase = er;
    snap_req = snap;
    frame_ack = ack;
    model_step(rstn, clr, wv, x, y, er, snap, ack);
    e.live  = m_img;
    e.frame = m_frame;
    e.fv    = m_fv;
    e.busy  = m_clearing;
    e.cnt   = 11'($countones(m_img));
    e.ready = !m_clearing && !clr;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic write(input int x, input int y, input bit er);
    cycle(1, 0, 1, x, y, er, 0, 0);
  endtask

  task automatic check_img(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    int fd;
    tests++;
    if (act !== exp) begin
      fails++;
      fd = -1;
      for (int i = 0; i < 1024; i++) if (act[i] !== exp[i]) begin fd = i; break; end
      $display("FAIL %s cyc=%0d first_diff_bit=%0d actual=%0b expected=%0b",
               name, cyc, fd, act[fd], exp[fd]);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: every cycle after the edge the DUT presents a new state; compare to the head.
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_img("live_image", live_image, e.live);
      check_img("frame_image", frame_image, e.frame);
      check_val("frame_valid", 32'(frame_valid), 32'(e.fv));
      check_val("busy", 32'(busy), 32'(e.busy));
      check_val("pix_count", 32'(pix_count), 32'(e.cnt));
      check_val("wr_ready", 32'(wr_ready), 32'(e.ready));
      check_val("dbg_state", 32'(dbg_state), e.busy ? 32'(CLEAR) : 32'(IDLE));
    end
  end

  initial begin
    rst_n = 0; wr_valid = 0; wr_x = 0; wr_y = 0; wr_erase = 0;
    clr_req = 0; snap_req = 0; frame_ack = 0;

    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Single write and idempotent rewrite.
    write(3, 5, 0);
    idle(1);
    write(3, 5, 0);
    idle(1);

    // 40 distinct pixels then a full sweep.
    for (int i = 0; i < 40; i++) write((i*25 % 1024) % 32, (i*25 % 1024) / 32, 0);
    cycle(1, 1, 0, 0, 0, 0, 0, 0);
    idle(34);

    // Clear and write offered together: clear wins.
    cycle(1, 1, 1, 0, 0, 0, 0, 0);
    idle(34);

    // Snapshot taken before a same-cycle write; second request ignored; ack releases.
    write(31, 31, 0);
    cycle(1, 0, 1, 0, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    cycle(1, 0, 0, 0, 0, 0, 1, 1);
    idle(1);
    cycle(1, 0, 0, 0, 0, 0, 0, 1);
    idle(1);

`ifdef CANVAS_ERASE_EN
    write(10, 10, 0);
    write(10, 10, 1);
    write(10, 10, 1);
    idle(1);
`endif

    // Reset in the middle of a sweep.
    for (int i = 0; i < 20; i++) write($urandom_range(0, 31), $urandom_range(0, 31), 0);
    cycle(1, 1, 0, 0, 0, 0, 1, 0);
    idle(9);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      cycle(1, ($urandom_range(0, 59) == 0), ($urandom_range(0, 9) < 7),
            $urandom_range(0, 31), $urandom_range(0, 31), ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
    end

    idle(1);
    repeat (3) @(negedge clk);
    check_val("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
